// File: rtl/axis_fifo_pkg.sv
// Shared constants and helpers for the AXI-Stream style FIFO.
// Optional error flags are enabled with AXIS_FIFO_ERR_FLAGS_EN.
package axis_fifo_pkg;

    localparam int DEF_M_WIDTH = 32;
    localparam int DEF_S_WIDTH = 32;
    localparam int DEF_DEPTH   = 8;

    // Pointer width for a power-of-two depth of at least two.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/axis_fifo_connect_if.sv
// Producer/consumer bundle for the FIFO; slave is the FIFO side.
// Error flag signals exist only with AXIS_FIFO_ERR_FLAGS_EN.
interface axis_fifo_connect_if #(
    parameter int S_WIDTH = 32,
    parameter int M_WIDTH = 32
) ();

    logic               write_en;
    logic [S_WIDTH-1:0] input_data;
    logic               pop_en;
    logic               full;
    logic               empty;
    logic [M_WIDTH-1:0] output_data;
`ifdef AXIS_FIFO_ERR_FLAGS_EN
    logic               overflow;
    logic               underflow;

    modport slave (
        input  write_en, input_data, pop_en,
        output full, empty, output_data, overflow, underflow
    );

    modport master (
        output write_en, input_data, pop_en,
        input  full, empty, output_data, overflow, underflow
    );
`else
    modport slave (
        input  write_en, input_data, pop_en,
        output full, empty, output_data
    );

    modport master (
        output write_en, input_data, pop_en,
        input  full, empty, output_data
    );
`endif

endinterface

// File: rtl/axis_fifo_mem.sv
// FIFO storage: synchronous write, asynchronous read.
// Contents are never reset; pointers and count define validity.
module axis_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store the pushed word at the write pointer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_fifo_connect.sv
// Single-clock FIFO with registered pop output and full/empty status.
// Define AXIS_FIFO_ERR_FLAGS_EN to add overflow/underflow pulses.
module axis_fifo_connect
    import axis_fifo_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH = DEF_M_WIDTH,
    parameter int C_S_AXIS_TDATA_WIDTH = DEF_S_WIDTH,
    parameter int FIFO_DEPTH           = DEF_DEPTH
) (
    input logic clk,
    input logic reset_n,
    axis_fifo_connect_if.slave bus
);

    localparam int AW = ptr_width(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          pop_acc;
    logic          wr_acc;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] rd_data;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] out_word;

    assign bus.full  = (count == FULL_CNT);
    assign bus.empty = (count == '0);

    // A pop frees a slot, so a write on full is taken alongside it.
    assign pop_acc = bus.pop_en & ~bus.empty;
    assign wr_acc  = bus.write_en & (~bus.full | pop_acc);

    axis_fifo_mem #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (C_S_AXIS_TDATA_WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (bus.input_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    generate
        if (C_M_AXIS_TDATA_WIDTH > C_S_AXIS_TDATA_WIDTH) begin : g_ext
            assign out_word = {
                {(C_M_AXIS_TDATA_WIDTH-C_S_AXIS_TDATA_WIDTH){1'b0}},
                rd_data
            };
        end else begin : g_trunc
            assign out_word = rd_data[C_M_AXIS_TDATA_WIDTH-1:0];
        end
    endgenerate

    // Pointers, occupancy count and the registered pop output.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            bus.output_data <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_acc) begin
                rd_ptr          <= rd_ptr + 1'b1;
                bus.output_data <= out_word;
            end
            case ({wr_acc, pop_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef AXIS_FIFO_ERR_FLAGS_EN
    // One-cycle pulses for a dropped write or an ignored pop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            bus.overflow  <= bus.write_en & ~wr_acc;
            bus.underflow <= bus.pop_en & bus.empty;
        end
    end
`endif

endmodule

// File: tb/tb_axis_fifo_connect.sv
// Directed self-checking bench for axis_fifo_connect.
// Checks flag pulses too when AXIS_FIFO_ERR_FLAGS_EN is defined.
module tb_axis_fifo_connect;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errs = 0;

    axis_fifo_connect_if #(.S_WIDTH(32), .M_WIDTH(32)) bus ();

    axis_fifo_connect #(
        .C_M_AXIS_TDATA_WIDTH (32),
        .C_S_AXIS_TDATA_WIDTH (32),
        .FIFO_DEPTH           (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply strobes for exactly one edge, then release them.
    task automatic op(input logic we, input logic [31:0] d,
                      input logic pe);
        bus.write_en   = we;
        bus.input_data = d;
        bus.pop_en     = pe;
        tick();
        bus.write_en = 1'b0;
        bus.pop_en   = 1'b0;
    endtask

    initial begin
        bus.write_en   = 1'b0;
        bus.input_data = '0;
        bus.pop_en     = 1'b0;

        // Reset
        reset_n = 1'b0;
        repeat (10) tick();
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_out", bus.output_data, 32'd0);
        reset_n = 1'b1;
        tick();

        // Fill then overflow
        for (int i = 0; i < 8; i++) begin
            op(1'b1, 32'(100 + i), 1'b0);
            check("fill_full", 32'(bus.full), (i == 7) ? 32'd1 : 32'd0);
            check("fill_empty", 32'(bus.empty), 32'd0);
        end
        op(1'b1, 32'd999, 1'b0);
        check("ovf_full", 32'(bus.full), 32'd1);
`ifdef AXIS_FIFO_ERR_FLAGS_EN
        check("ovf_pulse", 32'(bus.overflow), 32'd1);
        tick();
        check("ovf_clear", 32'(bus.overflow), 32'd0);
`endif

        // Drain then underflow
        for (int i = 0; i < 8; i++) begin
            op(1'b0, 32'd0, 1'b1);
            check("drain_out", bus.output_data, 32'(100 + i));
            check("drain_empty", 32'(bus.empty), (i == 7) ? 32'd1 : 32'd0);
            check("drain_full", 32'(bus.full), 32'd0);
        end
        op(1'b0, 32'd0, 1'b1);
        check("udf_out", bus.output_data, 32'd107);
        check("udf_empty", 32'(bus.empty), 32'd1);
`ifdef AXIS_FIFO_ERR_FLAGS_EN
        check("udf_pulse", 32'(bus.underflow), 32'd1);
        tick();
        check("udf_clear", 32'(bus.underflow), 32'd0);
`endif

        // Interleave write/pop across the pointer wrap
        for (int i = 0; i < 8; i++) begin
            op(1'b1, 32'(5 + 3 * i), 1'b0);
            check("ilv_nempty", 32'(bus.empty), 32'd0);
            op(1'b0, 32'd0, 1'b1);
            check("ilv_out", bus.output_data, 32'(5 + 3 * i));
            check("ilv_empty", 32'(bus.empty), 32'd1);
        end

        // Simultaneous write+pop starting from empty
        for (int i = 1; i <= 8; i++) begin
            op(1'b1, 32'(i), 1'b1);
            check("sim_out", bus.output_data,
                  (i == 1) ? 32'd26 : 32'(i - 1));
            check("sim_empty", 32'(bus.empty), 32'd0);
            tick();
        end
        op(1'b0, 32'd0, 1'b1);
        check("sim_last", bus.output_data, 32'd8);
        check("sim_drained", 32'(bus.empty), 32'd1);

        // Preload three, then steady-state write+pop
        op(1'b1, 32'd9, 1'b0);
        op(1'b1, 32'd99, 1'b0);
        op(1'b1, 32'd999, 1'b0);
        for (int i = 0; i < 8; i++) begin
            logic [31:0] exp;
            case (i)
                0:       exp = 32'd9;
                1:       exp = 32'd99;
                2:       exp = 32'd999;
                default: exp = 32'(99 + i - 3);
            endcase
            op(1'b1, 32'(99 + i), 1'b1);
            check("pre_out", bus.output_data, exp);
            check("pre_empty", 32'(bus.empty), 32'd0);
            check("pre_full", 32'(bus.full), 32'd0);
        end

        // Top up to full (104,105,106 remain), then write+pop on full
        for (int i = 0; i < 5; i++) begin
            op(1'b1, 32'(200 + i), 1'b0);
        end
        check("top_full", 32'(bus.full), 32'd1);
        op(1'b1, 32'd300, 1'b1);
        check("fullsim_out", bus.output_data, 32'd104);
        check("fullsim_full", 32'(bus.full), 32'd1);
`ifdef AXIS_FIFO_ERR_FLAGS_EN
        check("fullsim_novf", 32'(bus.overflow), 32'd0);
`endif
        for (int i = 0; i < 8; i++) begin
            logic [31:0] exp;
            case (i)
                0:       exp = 32'd105;
                1:       exp = 32'd106;
                7:       exp = 32'd300;
                default: exp = 32'(200 + i - 2);
            endcase
            op(1'b0, 32'd0, 1'b1);
            check("fin_out", bus.output_data, exp);
        end
        check("fin_empty", 32'(bus.empty), 32'd1);

        // Reset mid-operation discards contents
        op(1'b1, 32'd1, 1'b0);
        op(1'b1, 32'd2, 1'b0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mrst_empty", 32'(bus.empty), 32'd1);
        check("mrst_out", bus.output_data, 32'd0);
        op(1'b0, 32'd0, 1'b1);
        check("mrst_nopop", bus.output_data, 32'd0);
        op(1'b1, 32'd77, 1'b0);
        op(1'b0, 32'd0, 1'b1);
        check("mrst_pop", bus.output_data, 32'd77);
        check("mrst_end", 32'(bus.empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end

endmodule
